// File: rtl/apb_regfile_pkg.sv
// Shared types and address-map helper for the APB register-file/memory slave.
package apb_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DEC_REG  = 2'd0,
    DEC_MEM  = 2'd1,
    DEC_NONE = 2'd2
  } dec_t;

  // The memory window starts right after the last register slot.
  function automatic int mem_base(input int num_regs, input int reg_stride);
    return num_regs * reg_stride;
  endfunction

endpackage

// File: rtl/apb_regfile_mem_if.sv
// APB3 bus bundle between the bridge (master) and the register-file slave.
interface apb_regfile_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_regfile_sram.sv
// Word memory with per-byte write enables and a registered read port.
module apb_regfile_sram
  import apb_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_re,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int k = 0; k < NB; k++) begin
        if (i_wstrb[k]) r_mem[i_widx][k*8 +: 8] <= i_wdata[k*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_ridx];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/apb_regfile_mem.sv
// APB3 slave: register bank plus byte-addressable word memory, programmable wait states.
// Defining APB_REGFILE_SLVERR_EN enables PSLVERR for unmapped, unaligned and read-only writes.
//   state | meaning
//   IDLE  | waiting for a setup phase
//   WAIT  | inserting wait states, counter runs down to zero
//   RESP  | pready high for one cycle; write commits on the edge leaving
module apb_regfile_mem
  import apb_regfile_pkg::*;
#(
  parameter int                 DATA_WIDTH  = 32,
  parameter int                 ADDR_WIDTH  = 16,
  parameter int                 NUM_REGS    = 16,
  parameter int                 REG_STRIDE  = 64,
  parameter int                 MEM_DEPTH   = 1024,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_regfile_mem_if.slave bus
);
  localparam int NB         = DATA_WIDTH / 8;
  localparam int MEM_BASE   = mem_base(NUM_REGS, REG_STRIDE);
  localparam int MEM_TOP    = MEM_BASE + 4 * MEM_DEPTH;
  localparam int STRIDE_LSB = $clog2(REG_STRIDE);
  localparam int RIDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int MIDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef APB_REGFILE_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  if (longint'(MEM_TOP) > (longint'(1) << ADDR_WIDTH)) begin : g_addr_chk
    $error("apb_regfile_mem: memory window exceeds PADDR range");
  end

  state_t                r_state;
  logic [3:0]            r_cnt;
  dec_t                  r_dec;
  logic [RIDX_W-1:0]     r_ridx;
  logic [MIDX_W-1:0]     r_midx;
  logic                  r_write;
  logic                  r_err;
  logic                  r_ro;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic                  r_pready;
  logic                  r_pslverr;
  logic                  r_rd_mem;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [31:0]           w_baddr;
  dec_t                  w_bdec;
  logic [RIDX_W-1:0]     w_bridx;
  logic [MIDX_W-1:0]     w_bmidx;
  logic                  w_bro;
  logic                  w_berr;
  logic                  w_idle;
  logic                  w_setup;
  logic                  w_go_resp;
  dec_t                  w_cdec;
  logic [RIDX_W-1:0]     w_cridx;
  logic                  w_cwrite;
  logic                  w_cerr;
  logic                  w_commit;
  logic                  w_sram_we;
  logic [DATA_WIDTH-1:0] w_sram_q;

  // Byte offset inside the word never selects a location.
  assign w_baddr = 32'(bus.paddr) & ~32'd3;

  always_comb begin
    w_bdec  = DEC_NONE;
    w_bridx = '0;
    w_bmidx = '0;
    if (w_baddr < 32'(MEM_BASE)) begin
      if (w_baddr[STRIDE_LSB-1:0] == '0) begin
        w_bdec  = DEC_REG;
        w_bridx = RIDX_W'(w_baddr >> STRIDE_LSB);
      end
    end else if (w_baddr < 32'(MEM_TOP)) begin
      w_bdec  = DEC_MEM;
      w_bmidx = MIDX_W'((w_baddr - 32'(MEM_BASE)) >> 2);
    end
  end

  assign w_bro  = RO_MASK[w_bridx];
  assign w_berr = SLVERR_EN && ((w_bdec == DEC_NONE) || (bus.paddr[1:0] != 2'b00) ||
                                (bus.pwrite && (w_bdec == DEC_REG) && w_bro));

  assign w_idle  = (r_state == IDLE);
  assign w_setup = bus.psel && !bus.penable;

  // With zero wait states the response is built straight from the bus in the setup cycle.
  assign w_cdec   = w_idle ? w_bdec      : r_dec;
  assign w_cridx  = w_idle ? w_bridx     : r_ridx;
  assign w_cwrite = w_idle ? bus.pwrite  : r_write;
  assign w_cerr   = w_idle ? w_berr      : r_err;

  assign w_go_resp = (w_idle && w_setup && (WAIT_CYCLES == 0)) ||
                     ((r_state == WAIT) && bus.psel && (r_cnt == 4'd0));

  assign w_commit  = (r_state == RESP) && bus.psel && r_write && !r_err;
  assign w_sram_we = rst_n && w_commit && (r_dec == DEC_MEM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_dec     <= DEC_NONE;
      r_ridx    <= '0;
      r_midx    <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_ro      <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_mem  <= 1'b0;
      r_prdata  <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_rd_mem  <= 1'b0;
      r_prdata  <= '0;

      case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_dec   <= w_bdec;
            r_ridx  <= w_bridx;
            r_midx  <= w_bmidx;
            r_write <= bus.pwrite;
            r_err   <= w_berr;
            r_ro    <= w_bro;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
            if (WAIT_CYCLES == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!bus.psel)            r_state <= IDLE;
          else if (r_cnt == 4'd0)   r_state <= RESP;
          else                      r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (w_commit && (r_dec == DEC_REG) && !r_ro) begin
            for (int k = 0; k < NB; k++) begin
              if (r_strb[k]) r_regs[r_ridx][k*8 +: 8] <= r_wdata[k*8 +: 8];
            end
          end
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase

      if (w_go_resp) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_cerr;
        r_rd_mem  <= !w_cwrite && !w_cerr && (w_cdec == DEC_MEM);
        r_prdata  <= (!w_cwrite && !w_cerr && (w_cdec == DEC_REG)) ? r_regs[w_cridx] : '0;
      end
    end
  end

  // Memory is read on the setup edge so its registered output is ready in RESP.
  apb_regfile_sram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .IDX_W      (MIDX_W)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_widx  (r_midx),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_re    (w_idle && w_setup),
    .i_ridx  (w_bmidx),
    .o_rdata (w_sram_q)
  );

  assign bus.pready  = r_pready;
  assign bus.prdata  = r_rd_mem ? w_sram_q : r_prdata;
  assign bus.pslverr = r_pslverr;
endmodule

// File: doc/apb_regfile_mem.md
# apb_regfile_mem

Parametrised APB3 slave combining a configurable control/status register bank with a byte-addressable word memory. It replaces the fixed 16-register, zero-wait RAM slave with:
- configurable register count, spacing and memory depth
- programmable wait states
- per-register read-only masking
- optional PSLVERR signalling

It sits behind the APB bridge as a leaf peripheral.

## Interface
- DATA_WIDTH, 32, data bus width; multiple of 8
- ADDR_WIDTH, 16, PADDR width
- NUM_REGS, 16, number of registers; 1..32
- REG_STRIDE, 64, byte spacing between registers; power of two, ≥4
- MEM_DEPTH, 1024, memory words
- WAIT_CYCLES, 0, wait states inserted before PREADY; 0..15
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  1=write, 0=read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  byte write strobes
- pready  out  1  transfer complete
- prdata  out  DATA_WIDTH  read data, valid with pready on reads
- pslverr  out  1  error response, valid with pready

## Operation
**Address map**
- Register i: paddr == i*REG_STRIDE.
- MEM_BASE = NUM_REGS*REG_STRIDE.
- Memory: MEM_BASE ≤ paddr < MEM_BASE+4*MEM_DEPTH; word index = (paddr-MEM_BASE)>>2.
- Everything else is unmapped.
- Elaboration error if the memory top exceeds 2^ADDR_WIDTH.

**FSM: IDLE, WAIT, RESP**
- IDLE→RESP on psel & !penable when WAIT_CYCLES==0; otherwise IDLE→WAIT, loading cnt=WAIT_CYCLES-1.
- The setup edge latches paddr, pwrite, pwdata, pstrb and the decode result.
- WAIT: cnt decrements each cycle; at cnt==0 go to RESP.
- RESP: pready=1. Next state is IDLE.
- Read data is loaded into the prdata register on the edge entering RESP.
- Writes commit on the edge ending RESP. Only bytes with pstrb[k]=1 are updated; other bytes keep their value.
- psel=0 in WAIT or RESP aborts to IDLE: no write, pready stays 0.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted from IDLE.

**Write and read rules**
- Write to an RO register: data is discarded.
- Unmapped read: prdata=0.
- Unmapped write: discarded.
- prdata=0 whenever pready=0.
- pslverr=0 whenever pready=0.

## Timing
**Reset**
- pready=0, prdata=0, pslverr=0, state=IDLE.
- All registers reset to 0.
- Memory is not reset; contents are undefined until written.
- Reset asserted mid-transfer: the pending write is dropped; outputs return to reset values on the next edge.

**Latency**
- Setup phase in cycle T gives pready=1 in cycle T+1+WAIT_CYCLES, high for exactly one cycle.
- A write to a location is visible to a read whose setup starts in the cycle after RESP.

## Configuration
**APB_REGFILE_SLVERR_EN defined**
- pslverr=1 in RESP for: unmapped address, paddr[1:0]≠0, or write to an RO register.
- The write is suppressed in all three cases.
- prdata=0 on error.

**APB_REGFILE_SLVERR_EN undefined**
- pslverr is tied 0.
- paddr[1:0] is ignored.
- Unmapped and RO cases behave silently as in Operation.

## Structure
- Package apb_regfile_pkg holds:
  - state enum (IDLE, WAIT, RESP)
  - decode-result enum (DEC_REG, DEC_MEM, DEC_NONE)
  - helper function computing MEM_BASE
- Sub-module apb_regfile_sram: MEM_DEPTH×DATA_WIDTH array with a byte-enable write port and a registered read port, instantiated once.
- Register bank and FSM live in the top module.

## Test plan
- **Register write/readback:** WAIT_CYCLES=0; write 0x0040 = 0xDEADBEEF with pstrb=0xF, then read 0x0040 → prdata=0xDEADBEEF, pready in T+1, pslverr=0.
- **Partial strobe:** write 0x11223344 with pstrb=4'b0101 over 0xDEADBEEF → read returns 0xDE22BE44.
- **Memory and wait states:** WAIT_CYCLES=3; write 0x0404 = 0xCAFEF00D, read 0x0404 → pready exactly at T+4, prdata=0xCAFEF00D; reading 0x0400 does not return 0xCAFEF00D.
- **Read-only register:** RO_MASK bit2 set; write 0x0080 = 0xFFFFFFFF → reads back 0. pslverr=1 with the macro, 0 without.
- **Errors:** read 0xFFF0 → prdata=0, pslverr=1 (macro). Read 0x0042 → pslverr=1 (macro); without the macro it aliases to 0x0040.
- **Abort and reset:** drop psel during WAIT → no write, pready never asserted. Assert rst_n=0 during WAIT → next cycle pready=0, register 1 reads 0 after reset.
